// File: rtl/xpm_memory_tdpram.sv
// True dual-port RAM on one clock. Byte-lane writes, write_first reads, and port B wins lane collisions.
// Read latency is 1 or 2 (second stage gated by regce). No backpressure: an access is accepted on every edge.
module xpm_memory_tdpram #(
  parameter int ADDR_WIDTH_A        = 6,
  parameter int ADDR_WIDTH_B        = 6,
  parameter int MEMORY_SIZE         = 2048,
  parameter int WRITE_DATA_WIDTH_A  = 32,
  parameter int WRITE_DATA_WIDTH_B  = 32,
  parameter int READ_DATA_WIDTH_A   = 32,
  parameter int READ_DATA_WIDTH_B   = 32,
  parameter int BYTE_WRITE_WIDTH_A  = 32,
  parameter int BYTE_WRITE_WIDTH_B  = 32,
  parameter int READ_LATENCY_A      = 1,
  parameter int READ_LATENCY_B      = 1,
  parameter     WRITE_MODE_A        = "write_first",
  parameter     WRITE_MODE_B        = "write_first",
  parameter     CLOCKING_MODE       = "common_clock",
  parameter     ECC_MODE            = "no_ecc",
  parameter int AUTO_SLEEP_TIME     = 0,
  parameter int CASCADE_HEIGHT      = 0,
  parameter int IGNORE_INIT_SYNTH   = 0,
  parameter     MEMORY_INIT_FILE    = "none",
  parameter     MEMORY_INIT_PARAM   = "0",
  parameter     MEMORY_OPTIMIZATION = "true",
  parameter     MEMORY_PRIMITIVE    = "auto",
  parameter int MESSAGE_CONTROL     = 0,
  parameter int USE_MEM_INIT        = 1,
  parameter int WRITE_PROTECT       = 1
) (
  input  logic                                               clka,
  input  logic                                               clkb,
  input  logic                                               rsta,
  input  logic                                               rstb,
  input  logic [ADDR_WIDTH_A-1:0]                            addra,
  input  logic [ADDR_WIDTH_B-1:0]                            addrb,
  input  logic [WRITE_DATA_WIDTH_A-1:0]                      dina,
  input  logic [WRITE_DATA_WIDTH_B-1:0]                      dinb,
  input  logic                                               ena,
  input  logic                                               enb,
  input  logic [WRITE_DATA_WIDTH_A/BYTE_WRITE_WIDTH_A-1:0]   wea,
  input  logic [WRITE_DATA_WIDTH_B/BYTE_WRITE_WIDTH_B-1:0]   web,
  input  logic                                               regcea,
  input  logic                                               regceb,
  input  logic                                               sleep,
  input  logic                                               injectsbiterra,
  input  logic                                               injectdbiterra,
  input  logic                                               injectsbiterrb,
  input  logic                                               injectdbiterrb,
  output logic [READ_DATA_WIDTH_A-1:0]                       douta,
  output logic [READ_DATA_WIDTH_B-1:0]                       doutb,
  output logic                                               sbiterra,
  output logic                                               dbiterra,
  output logic                                               sbiterrb,
  output logic                                               dbiterrb
);

  localparam int          DW      = WRITE_DATA_WIDTH_A;
  localparam int          DEPTH   = MEMORY_SIZE / WRITE_DATA_WIDTH_A;
  localparam int          IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          NL_A    = WRITE_DATA_WIDTH_A / BYTE_WRITE_WIDTH_A;
  localparam int          NL_B    = WRITE_DATA_WIDTH_B / BYTE_WRITE_WIDTH_B;
  localparam logic [31:0] DEPTH_U = 32'(DEPTH);

  logic [DW-1:0]    mem_q [0:DEPTH-1];
  logic [IDX_W-1:0] idx_a, idx_b;
  logic             in_a, in_b;
  logic             wr_ok_a, wr_ok_b;
  logic [NL_A-1:0]  we_a;
  logic [NL_B-1:0]  we_b;
  logic [DW-1:0]    word_a, word_b;
  logic [DW-1:0]    rd_a_d, rd_a_q, rd_b_d, rd_b_q;

  assign idx_a   = IDX_W'(addra);
  assign idx_b   = IDX_W'(addrb);
  assign in_a    = 32'(addra) < DEPTH_U;
  assign in_b    = 32'(addrb) < DEPTH_U;
  assign wr_ok_a = ena | (WRITE_PROTECT == 0);
  assign wr_ok_b = enb | (WRITE_PROTECT == 0);
  assign we_a    = (wr_ok_a && in_a) ? wea : '0;
  assign we_b    = (wr_ok_b && in_b) ? web : '0;
  // Pre-write word; out-of-range addresses read as zero.
  assign word_a  = in_a ? mem_q[idx_a] : '0;
  assign word_b  = in_b ? mem_q[idx_b] : '0;

  // Each port sees its own write lanes merged over the pre-write word, never the other port's.
  always_comb begin
    rd_a_d = rd_a_q;
    if (ena) begin
      rd_a_d = word_a;
      for (int i = 0; i < NL_A; i++) begin
        if (we_a[i]) rd_a_d[i*BYTE_WRITE_WIDTH_A +: BYTE_WRITE_WIDTH_A] = dina[i*BYTE_WRITE_WIDTH_A +: BYTE_WRITE_WIDTH_A];
      end
    end
  end

  always_comb begin
    rd_b_d = rd_b_q;
    if (enb) begin
      rd_b_d = word_b;
      for (int i = 0; i < NL_B; i++) begin
        if (we_b[i]) rd_b_d[i*BYTE_WRITE_WIDTH_B +: BYTE_WRITE_WIDTH_B] = dinb[i*BYTE_WRITE_WIDTH_B +: BYTE_WRITE_WIDTH_B];
      end
    end
  end

  // Port B lanes are assigned last, so they win when both ports hit the same lane.
  always_ff @(posedge clka) begin
    for (int i = 0; i < NL_A; i++) begin
      if (we_a[i]) mem_q[idx_a][i*BYTE_WRITE_WIDTH_A +: BYTE_WRITE_WIDTH_A] <= dina[i*BYTE_WRITE_WIDTH_A +: BYTE_WRITE_WIDTH_A];
    end
    for (int i = 0; i < NL_B; i++) begin
      if (we_b[i]) mem_q[idx_b][i*BYTE_WRITE_WIDTH_B +: BYTE_WRITE_WIDTH_B] <= dinb[i*BYTE_WRITE_WIDTH_B +: BYTE_WRITE_WIDTH_B];
    end
  end

  always_ff @(posedge clka) begin
    if (rsta) rd_a_q <= '0;
    else      rd_a_q <= rd_a_d;
    if (rstb) rd_b_q <= '0;
    else      rd_b_q <= rd_b_d;
  end

  if (READ_LATENCY_A == 2) begin : g_a_l2
    logic [DW-1:0] dout_a_d, dout_a_q;
    always_comb begin
      dout_a_d = dout_a_q;
      if (regcea) dout_a_d = rd_a_q;
    end
    always_ff @(posedge clka) begin
      if (rsta) dout_a_q <= '0;
      else      dout_a_q <= dout_a_d;
    end
    assign douta = dout_a_q;
  end else begin : g_a_l1
    assign douta = rd_a_q;
  end

  if (READ_LATENCY_B == 2) begin : g_b_l2
    logic [DW-1:0] dout_b_d, dout_b_q;
    always_comb begin
      dout_b_d = dout_b_q;
      if (regceb) dout_b_d = rd_b_q;
    end
    always_ff @(posedge clka) begin
      if (rstb) dout_b_q <= '0;
      else      dout_b_q <= dout_b_d;
    end
    assign doutb = dout_b_q;
  end else begin : g_b_l1
    assign doutb = rd_b_q;
  end

  assign sbiterra = 1'b0;
  assign dbiterra = 1'b0;
  assign sbiterrb = 1'b0;
  assign dbiterrb = 1'b0;

  logic unused_ok;
  assign unused_ok = &{1'b0, clkb, sleep, regcea, regceb,
                       injectsbiterra, injectdbiterra, injectsbiterrb, injectdbiterrb};

endmodule

// File: tb/tb_xpm_memory_tdpram.sv
// Directed bench for xpm_memory_tdpram: 32-bit words, 8-bit lanes, 1024 words.
// Runs a latency-1 and a latency-2 instance side by side on the same stimulus.
module tb_xpm_memory_tdpram;

  logic        clk;
  logic        rsta, rstb, ena, enb, regcea, regceb;
  logic [10:0] addra, addrb;
  logic [31:0] dina, dinb;
  logic [3:0]  wea, web;
  logic [31:0] douta1, doutb1, douta2, doutb2;
  logic        sbea1, dbea1, sbeb1, dbeb1, sbea2, dbea2, sbeb2, dbeb2;

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  xpm_memory_tdpram #(
    .ADDR_WIDTH_A(11), .ADDR_WIDTH_B(11), .MEMORY_SIZE(32768),
    .BYTE_WRITE_WIDTH_A(8), .BYTE_WRITE_WIDTH_B(8),
    .READ_LATENCY_A(1), .READ_LATENCY_B(1)
  ) u_l1 (
    .clka(clk), .clkb(clk), .rsta(rsta), .rstb(rstb),
    .addra(addra), .addrb(addrb), .dina(dina), .dinb(dinb),
    .ena(ena), .enb(enb), .wea(wea), .web(web),
    .regcea(regcea), .regceb(regceb), .sleep(1'b0),
    .injectsbiterra(1'b0), .injectdbiterra(1'b0),
    .injectsbiterrb(1'b0), .injectdbiterrb(1'b0),
    .douta(douta1), .doutb(doutb1),
    .sbiterra(sbea1), .dbiterra(dbea1), .sbiterrb(sbeb1), .dbiterrb(dbeb1)
  );

  xpm_memory_tdpram #(
    .ADDR_WIDTH_A(11), .ADDR_WIDTH_B(11), .MEMORY_SIZE(32768),
    .BYTE_WRITE_WIDTH_A(8), .BYTE_WRITE_WIDTH_B(8),
    .READ_LATENCY_A(2), .READ_LATENCY_B(2)
  ) u_l2 (
    .clka(clk), .clkb(clk), .rsta(rsta), .rstb(rstb),
    .addra(addra), .addrb(addrb), .dina(dina), .dinb(dinb),
    .ena(ena), .enb(enb), .wea(wea), .web(web),
    .regcea(regcea), .regceb(regceb), .sleep(1'b0),
    .injectsbiterra(1'b0), .injectdbiterra(1'b0),
    .injectsbiterrb(1'b0), .injectdbiterrb(1'b0),
    .douta(douta2), .doutb(doutb2),
    .sbiterra(sbea2), .dbiterra(dbea2), .sbiterrb(sbeb2), .dbiterrb(dbeb2)
  );

  typedef struct {
    logic        ena;
    logic [3:0]  wea;
    logic [10:0] addra;
    logic [31:0] dina;
    logic        enb;
    logic [3:0]  web;
    logic [10:0] addrb;
    logic [31:0] dinb;
    logic        rsta;
    logic        rstb;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic ea, logic [3:0] wa, logic [10:0] aa, logic [31:0] da,
                              logic eb, logic [3:0] wb, logic [10:0] ab, logic [31:0] db,
                              logic ra, logic rb, logic [31:0] xa, logic [31:0] xb);
    vec_t v;
    v.ena = ea; v.wea = wa; v.addra = aa; v.dina = da;
    v.enb = eb; v.web = wb; v.addrb = ab; v.dinb = db;
    v.rsta = ra; v.rstb = rb; v.exp_a = xa; v.exp_b = xb;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ena = 1'b0; enb = 1'b0; wea = 4'h0; web = 4'h0;
    addra = 11'd0; addrb = 11'd0; dina = 32'h0; dinb = 32'h0;
    rsta = 1'b0; rstb = 1'b0;
  endtask

  initial begin
    idle_inputs();
    regcea = 1'b0; regceb = 1'b0;

    //          ena wea   addra    dina          enb web   addrb   dinb          ra rb exp_a         exp_b
    vecs.push_back(mk(0, 4'h0, 11'd0,    32'h0,        0, 4'h0, 11'd0, 32'h0,        1, 1, 32'h0,        32'h0));
    vecs.push_back(mk(0, 4'h0, 11'd0,    32'h0,        0, 4'h0, 11'd0, 32'h0,        0, 0, 32'h0,        32'h0));
    vecs.push_back(mk(1, 4'hF, 11'd5,    32'hDEADBEEF, 0, 4'h0, 11'd0, 32'h0,        0, 0, 32'hDEADBEEF, 32'h0));
    vecs.push_back(mk(0, 4'h0, 11'd0,    32'h0,        1, 4'h0, 11'd5, 32'h0,        0, 0, 32'hDEADBEEF, 32'hDEADBEEF));
    vecs.push_back(mk(1, 4'hF, 11'd7,    32'h11223344, 0, 4'h0, 11'd0, 32'h0,        0, 0, 32'h11223344, 32'hDEADBEEF));
    vecs.push_back(mk(1, 4'h5, 11'd7,    32'hAABBCCDD, 0, 4'h0, 11'd0, 32'h0,        0, 0, 32'h11BB33DD, 32'hDEADBEEF));
    vecs.push_back(mk(0, 4'h0, 11'd0,    32'h0,        1, 4'h0, 11'd7, 32'h0,        0, 0, 32'h11BB33DD, 32'h11BB33DD));
    vecs.push_back(mk(1, 4'hF, 11'd9,    32'h0,        0, 4'h0, 11'd0, 32'h0,        0, 0, 32'h0,        32'h11BB33DD));
    vecs.push_back(mk(1, 4'h0, 11'd5,    32'h0,        0, 4'h0, 11'd0, 32'h0,        0, 0, 32'hDEADBEEF, 32'h11BB33DD));
    vecs.push_back(mk(0, 4'hF, 11'd9,    32'hFFFFFFFF, 0, 4'h0, 11'd0, 32'h0,        0, 0, 32'hDEADBEEF, 32'h11BB33DD));
    vecs.push_back(mk(1, 4'h0, 11'd9,    32'h0,        0, 4'h0, 11'd0, 32'h0,        0, 0, 32'h0,        32'h11BB33DD));
    vecs.push_back(mk(0, 4'h0, 11'd0,    32'h0,        1, 4'hF, 11'd3, 32'h9,        0, 0, 32'h0,        32'h9));
    vecs.push_back(mk(1, 4'hF, 11'd3,    32'h1,        1, 4'h0, 11'd3, 32'h0,        0, 0, 32'h1,        32'h9));
    vecs.push_back(mk(0, 4'h0, 11'd0,    32'h0,        1, 4'h0, 11'd3, 32'h0,        0, 0, 32'h1,        32'h1));
    vecs.push_back(mk(1, 4'hF, 11'd3,    32'hA5A5A5A5, 1, 4'hF, 11'd3, 32'h5A5A5A5A, 0, 0, 32'hA5A5A5A5, 32'h5A5A5A5A));
    vecs.push_back(mk(1, 4'h0, 11'd3,    32'h0,        0, 4'h0, 11'd0, 32'h0,        0, 0, 32'h5A5A5A5A, 32'h5A5A5A5A));
    vecs.push_back(mk(1, 4'h3, 11'd3,    32'h11111111, 1, 4'h6, 11'd3, 32'h22222222, 0, 0, 32'h5A5A1111, 32'h5A22225A));
    vecs.push_back(mk(0, 4'h0, 11'd0,    32'h0,        1, 4'h0, 11'd3, 32'h0,        0, 0, 32'h5A5A1111, 32'h5A222211));
    vecs.push_back(mk(1, 4'hF, 11'd5,    32'hCAFEF00D, 1, 4'h0, 11'd7, 32'h0,        1, 0, 32'h0,        32'h11BB33DD));
    vecs.push_back(mk(1, 4'h0, 11'd5,    32'h0,        0, 4'h0, 11'd0, 32'h0,        0, 0, 32'hCAFEF00D, 32'h11BB33DD));
    vecs.push_back(mk(0, 4'h0, 11'd0,    32'h0,        1, 4'hF, 11'd0, 32'h0BADC0DE, 0, 0, 32'hCAFEF00D, 32'h0BADC0DE));
    vecs.push_back(mk(1, 4'hF, 11'd1024, 32'h12345678, 0, 4'h0, 11'd0, 32'h0,        0, 0, 32'h0,        32'h0BADC0DE));
    vecs.push_back(mk(1, 4'h0, 11'd2047, 32'h0,        1, 4'h0, 11'd0, 32'h0,        0, 0, 32'h0,        32'h0BADC0DE));
    vecs.push_back(mk(1, 4'h0, 11'd5,    32'h0,        1, 4'h0, 11'd0, 32'h0,        0, 1, 32'hCAFEF00D, 32'h0));
    vecs.push_back(mk(0, 4'h0, 11'd0,    32'h0,        0, 4'h0, 11'd0, 32'h0,        0, 0, 32'hCAFEF00D, 32'h0));

    repeat (2) tick();
    foreach (vecs[k]) begin
      ena = vecs[k].ena; wea = vecs[k].wea; addra = vecs[k].addra; dina = vecs[k].dina;
      enb = vecs[k].enb; web = vecs[k].web; addrb = vecs[k].addrb; dinb = vecs[k].dinb;
      rsta = vecs[k].rsta; rstb = vecs[k].rstb;
      tick();
      check($sformatf("vec%0d_douta", k), douta1, vecs[k].exp_a);
      check($sformatf("vec%0d_doutb", k), doutb1, vecs[k].exp_b);
    end
    check("err_flags", {28'h0, sbea1 | sbea2, dbea1 | dbea2, sbeb1 | sbeb2, dbeb1 | dbeb2}, 32'h0);

    // Latency-2 output stage: regce gating and two-edge latency.
    idle_inputs();
    check("l2_after_table", douta2, 32'h0);
    ena = 1'b1; addra = 11'd7; regcea = 1'b0;
    tick();
    check("l1_read7", douta1, 32'h11BB33DD);
    check("l2_hold_regce0", douta2, 32'h0);
    ena = 1'b0;
    tick();
    check("l2_hold_again", douta2, 32'h0);
    regcea = 1'b1;
    tick();
    check("l2_regce_load", douta2, 32'h11BB33DD);
    ena = 1'b1; addra = 11'd5;
    tick();
    check("l2_lat_edge1", douta2, 32'h11BB33DD);
    ena = 1'b0;
    tick();
    check("l2_lat_edge2", douta2, 32'hCAFEF00D);

    enb = 1'b1; addrb = 11'd0; regceb = 1'b1;
    tick();
    check("l2b_lat_edge1", doutb2, 32'h0);
    enb = 1'b0;
    tick();
    check("l2b_lat_edge2", doutb2, 32'h0BADC0DE);

    rsta = 1'b1;
    tick();
    check("l2_rsta_clear", douta2, 32'h0);
    check("l2_rsta_b_keep", doutb2, 32'h0BADC0DE);
    rsta = 1'b0; regcea = 1'b1;
    tick();
    check("l2_post_rst_hold", douta2, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/xpm_memory_tdpram.md
XPM_MEMORY_TDPRAM -- requirements
Module: xpm_memory_tdpram

Interface
REQ-001 SHALL expose the following parameters, each given as name, default, meaning:
- ADDR_WIDTH_A/ADDR_WIDTH_B, 6: address width per port.
- MEMORY_SIZE, 2048: total bits; depth = MEMORY_SIZE/WRITE_DATA_WIDTH_A.
- WRITE_DATA_WIDTH_A/_B, 32: write width per port.
- READ_DATA_WIDTH_A/_B, 32: read width per port; must equal the write width.
- BYTE_WRITE_WIDTH_A/_B, 32: bits per write-enable lane; must be 8 or equal to the data width.
- READ_LATENCY_A/_B, 1: read latency; values 1 or 2 supported.
- WRITE_MODE_A/_B, "write_first": write mode; only "write_first" is supported.
- CLOCKING_MODE, "common_clock": only "common_clock" is supported.
- ECC_MODE, "no_ecc": only "no_ecc" is supported.
- AUTO_SLEEP_TIME, CASCADE_HEIGHT, IGNORE_INIT_SYNTH, MEMORY_INIT_FILE, MEMORY_INIT_PARAM, MEMORY_OPTIMIZATION, MEMORY_PRIMITIVE, MESSAGE_CONTROL, USE_MEM_INIT: accepted and functionally ignored.
- WRITE_PROTECT, 1: writes are gated by the port enable.

REQ-002 Clocking and reset are fixed: one clock, and reset is synchronous and active-high. Ports are given as name, direction, width, meaning:
- clka, in, 1: the single clock; all state is updated on its rising edge.
- clkb, in, 1: tied to the same net as clka; unused internally.
- rsta / rstb, in, 1: synchronous active-high reset of the port A / port B output path.
- addra / addrb, in, ADDR_WIDTH_A / ADDR_WIDTH_B: word address.
- dina / dinb, in, WRITE_DATA_WIDTH_A/_B: write data.
- ena / enb, in, 1: port enable.
- wea / web, in, WRITE_DATA_WIDTH/BYTE_WRITE_WIDTH: per-lane write enable.
- regcea / regceb, in, 1: output-register clock enable; used only when latency = 2.
- sleep, in, 1: ignored.
- injectsbiterra/b, injectdbiterra/b, in, 1: ignored.
- douta / doutb, out, READ_DATA_WIDTH_A/_B: read data.
- sbiterra/b, dbiterra/b, out, 1: constant 0.

Function
REQ-003 Storage SHALL be an array of depth words, each WRITE_DATA_WIDTH bits, shared by both ports; the array itself is never reset.
REQ-004 When ena=1 on a clock edge, for each lane i with wea[i]=1, bits [i*BW +: BW] of mem[addra] SHALL take the corresponding bits of dina.
REQ-005 When ena=0, port A SHALL neither write nor update its read stage, regardless of wea (write protect).
REQ-006 Read, latency 1: when ena=1 the port A data register SHALL load the new word at the edge; written lanes take dina and unwritten lanes take the prior contents (write_first). douta is valid in the cycle after the address is presented.
REQ-007 Read, latency 2: the stage-1 register SHALL behave as in REQ-006; douta SHALL load stage-1 when regcea=1 and hold otherwise, giving a total latency of 2.
REQ-008 Port B SHALL behave identically to port A using addrb, enb, web, dinb, regceb, rstb and doutb.
REQ-009 When both ports write the same address on the same edge, lanes written by only one port SHALL take that port's data, and lanes written by both SHALL take dinb (port B wins).
REQ-010 When one port reads an address that the other port writes on the same edge, the reading port SHALL return the pre-write contents; its own write_first behaviour applies only to its own writes.
REQ-011 Out-of-range addresses (address >= depth) SHALL not write, and SHALL read as 0.
REQ-012 The combined write-enable of a port SHALL be the per-lane wea/web vector; with BYTE_WRITE_WIDTH equal to the data width, it is a single-bit whole-word enable.

Reset
REQ-013 rsta=1 on an edge SHALL clear douta, and the port A stage-1 register, to 0 at that edge, overriding any read; rstb does the same for port B.
REQ-014 Reset SHALL NOT block writes: an asserted ena with wea during rsta still updates memory.
REQ-015 After reset deasserts, douta and doutb SHALL hold 0 until the next enabled read.

Verification
The directed scenarios below use a 32-bit width, 8-bit lanes, 1024 words and latency 1 unless stated.
REQ-016 Port A writes 0xDEADBEEF to address 5 (wea=4'hF) -> douta=0xDEADBEEF the next cycle (write_first); a later port B read of address 5 -> doutb=0xDEADBEEF one cycle after.
REQ-017 Word 7 holds 0x11223344; port A writes 0xAABBCCDD with wea=4'b0101 -> douta=0x11BB33DD, and memory holds the same value.
REQ-018 With ena=0 and wea=4'hF, drive dina=0xFFFFFFFF to address 9 holding 0 -> memory is unchanged and douta holds its previous value.
REQ-019 Same edge: port A writes 0x1 to address 3 and port B reads address 3, which holds 0x9 -> doutb=0x9; a subsequent port B read -> 0x1. Both ports write address 3 with full enables -> stored value = dinb.
REQ-020 Assert rsta while ena=1 reads address 5 -> douta=0 at that edge; doutb is unaffected; the write issued during reset is visible on a later read.
REQ-021 Latency-2 build: after a read, with regcea=0 douta holds its old value; asserting regcea -> douta updates one edge later.
